// File: rtl/clause_db_ctrl_if.sv
// Bundle of requester, sweep-stream and storage-array signals around the clause DB controller.
// The controller attaches through the slave modport; requesters/storage model use master.
interface clause_db_ctrl_if #(
  parameter int DB_SIZE = 512,
  parameter int VAR_W   = 9,
  parameter int LITS    = 5
);
  localparam int CW = $clog2(DB_SIZE);

  logic                  clear;
  logic                  load_valid;
  logic                  load_ready;
  logic [LITS-1:0]       load_mask;
  logic [LITS-1:0]       load_pole;
  logic [LITS*VAR_W-1:0] load_vars;
  logic                  overflow;

  logic                  rd_req;
  logic [CW-1:0]         rd_idx;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [LITS-1:0]       rd_mask;
  logic [LITS-1:0]       rd_pole;
  logic [LITS*VAR_W-1:0] rd_vars;

  logic                  sweep_start;
  logic                  sweep_abort;
  logic                  sweep_busy;
  logic                  sweep_done;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         out_idx;
  logic [LITS-1:0]       out_mask;
  logic [LITS-1:0]       out_pole;
  logic [LITS*VAR_W-1:0] out_vars;

  logic [CW:0]           clause_count;
  logic                  full;

  logic                  db_we;
  logic                  db_re;
  logic [CW-1:0]         db_addr;
  logic [LITS-1:0]       db_mask_wr;
  logic [LITS-1:0]       db_pole_wr;
  logic [LITS*VAR_W-1:0] db_vars_wr;
  logic [LITS-1:0]       db_mask_rd;
  logic [LITS-1:0]       db_pole_rd;
  logic [LITS*VAR_W-1:0] db_vars_rd;

  modport slave (
    input  clear, load_valid, load_mask, load_pole, load_vars,
    input  rd_req, rd_idx, sweep_start, sweep_abort, out_ready,
    input  db_mask_rd, db_pole_rd, db_vars_rd,
    output load_ready, overflow, rd_gnt, rd_valid, rd_mask, rd_pole, rd_vars,
    output sweep_busy, sweep_done, out_valid, out_idx, out_mask, out_pole, out_vars,
    output clause_count, full, db_we, db_re, db_addr, db_mask_wr, db_pole_wr, db_vars_wr
  );

  modport master (
    output clear, load_valid, load_mask, load_pole, load_vars,
    output rd_req, rd_idx, sweep_start, sweep_abort, out_ready,
    output db_mask_rd, db_pole_rd, db_vars_rd,
    input  load_ready, overflow, rd_gnt, rd_valid, rd_mask, rd_pole, rd_vars,
    input  sweep_busy, sweep_done, out_valid, out_idx, out_mask, out_pole, out_vars,
    input  clause_count, full, db_we, db_re, db_addr, db_mask_wr, db_pole_wr, db_vars_wr
  );
endinterface

// File: rtl/clause_db_ctrl.sv
// Clause database controller: arbitrates loader appends, solver random reads and
// BCP full sweeps onto a single-port storage array with one-cycle read latency.
module clause_db_ctrl #(
  parameter int DB_SIZE = 512,
  parameter int VAR_W   = 9,
  parameter int LITS    = 5
) (
  input  logic             clock,
  input  logic             reset,
  clause_db_ctrl_if.slave  bus
);
  localparam int          CW       = $clog2(DB_SIZE);
  localparam logic [CW:0] FULL_CNT = (CW+1)'(DB_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAND_WAIT,
    S_SWEEP_ISSUE,
    S_SWEEP_WAIT,
    S_SWEEP_OUT
  } state_t;

  state_t                state_q, state_d;
  logic [CW:0]           count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic [CW-1:0]         sweep_idx_q, sweep_idx_d;
  logic                  rd_oor_q, rd_oor_d;
  logic                  sweep_done_q, sweep_done_d;
  logic                  out_valid_q, out_valid_d;
  logic [CW-1:0]         out_idx_q, out_idx_d;
  logic [LITS-1:0]       out_mask_q, out_mask_d;
  logic [LITS-1:0]       out_pole_q, out_pole_d;
  logic [LITS*VAR_W-1:0] out_vars_q, out_vars_d;

  logic                  full_w;
  logic                  in_sweep;
  logic                  load_ready_c, rd_gnt_c, db_we_c, db_re_c;
  logic [CW-1:0]         db_addr_c;
  logic [LITS-1:0]       db_mask_wr_c, db_pole_wr_c;
  logic [LITS*VAR_W-1:0] db_vars_wr_c;

  assign full_w   = (count_q == FULL_CNT);
  assign in_sweep = (state_q == S_SWEEP_ISSUE) || (state_q == S_SWEEP_WAIT) ||
                    (state_q == S_SWEEP_OUT);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    sweep_idx_d  = sweep_idx_q;
    rd_oor_d     = rd_oor_q;
    sweep_done_d = 1'b0;
    out_valid_d  = out_valid_q;
    out_idx_d    = out_idx_q;
    out_mask_d   = out_mask_q;
    out_pole_d   = out_pole_q;
    out_vars_d   = out_vars_q;
    load_ready_c = 1'b0;
    rd_gnt_c     = 1'b0;
    db_we_c      = 1'b0;
    db_re_c      = 1'b0;
    db_addr_c    = '0;
    db_mask_wr_c = '0;
    db_pole_wr_c = '0;
    db_vars_wr_c = '0;

    // Strobes are gated by reset so every output reads 0 while reset is held.
    if (!reset) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.clear) begin
            count_d = '0;
          end else begin
            load_ready_c = !full_w;
            if (bus.load_valid && full_w) begin
              overflow_d = 1'b1;
            end
            if (bus.load_valid && !full_w) begin
              db_we_c      = 1'b1;
              db_addr_c    = count_q[CW-1:0];
              db_mask_wr_c = bus.load_mask;
              db_pole_wr_c = bus.load_pole;
              db_vars_wr_c = bus.load_vars;
              count_d      = count_q + (CW+1)'(1);
            end else if (bus.rd_req) begin
              rd_gnt_c = 1'b1;
              state_d  = S_RAND_WAIT;
              if ({1'b0, bus.rd_idx} < count_q) begin
                db_re_c   = 1'b1;
                db_addr_c = bus.rd_idx;
                rd_oor_d  = 1'b0;
              end else begin
                rd_oor_d  = 1'b1;
              end
            end else if (bus.sweep_start) begin
              if (count_q == '0) begin
                sweep_done_d = 1'b1;
              end else begin
                sweep_idx_d = '0;
                state_d     = S_SWEEP_ISSUE;
              end
            end
          end
        end
        S_RAND_WAIT: state_d = S_IDLE;
        S_SWEEP_ISSUE: begin
          db_re_c   = 1'b1;
          db_addr_c = sweep_idx_q;
          state_d   = S_SWEEP_WAIT;
        end
        S_SWEEP_WAIT: begin
          out_idx_d   = sweep_idx_q;
          out_mask_d  = bus.db_mask_rd;
          out_pole_d  = bus.db_pole_rd;
          out_vars_d  = bus.db_vars_rd;
          out_valid_d = 1'b1;
          state_d     = S_SWEEP_OUT;
        end
        S_SWEEP_OUT: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
            if ({1'b0, sweep_idx_q} == count_q - (CW+1)'(1)) begin
              sweep_done_d = 1'b1;
              state_d      = S_IDLE;
            end else begin
              sweep_idx_d = sweep_idx_q + CW'(1);
              state_d     = S_SWEEP_ISSUE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Abort overrides whatever the sweep states decided, including a handshake.
      if (in_sweep && bus.sweep_abort) begin
        state_d      = S_IDLE;
        out_valid_d  = 1'b0;
        sweep_done_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      sweep_idx_q  <= '0;
      rd_oor_q     <= 1'b0;
      sweep_done_q <= 1'b0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_mask_q   <= '0;
      out_pole_q   <= '0;
      out_vars_q   <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      sweep_idx_q  <= sweep_idx_d;
      rd_oor_q     <= rd_oor_d;
      sweep_done_q <= sweep_done_d;
      out_valid_q  <= out_valid_d;
      out_idx_q    <= out_idx_d;
      out_mask_q   <= out_mask_d;
      out_pole_q   <= out_pole_d;
      out_vars_q   <= out_vars_d;
    end
  end

  assign bus.load_ready   = load_ready_c;
  assign bus.overflow     = overflow_q;
  assign bus.rd_gnt       = rd_gnt_c;
  assign bus.rd_valid     = !reset && (state_q == S_RAND_WAIT);
  // Read data is a pass-through of the array, forced to zero for out-of-range requests.
  assign bus.rd_mask      = (bus.rd_valid && !rd_oor_q) ? bus.db_mask_rd : '0;
  assign bus.rd_pole      = (bus.rd_valid && !rd_oor_q) ? bus.db_pole_rd : '0;
  assign bus.rd_vars      = (bus.rd_valid && !rd_oor_q) ? bus.db_vars_rd : '0;
  assign bus.sweep_busy   = !reset && in_sweep;
  assign bus.sweep_done   = sweep_done_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_idx      = out_idx_q;
  assign bus.out_mask     = out_mask_q;
  assign bus.out_pole     = out_pole_q;
  assign bus.out_vars     = out_vars_q;
  assign bus.clause_count = count_q;
  assign bus.full         = full_w;
  assign bus.db_we        = db_we_c;
  assign bus.db_re        = db_re_c;
  assign bus.db_addr      = db_addr_c;
  assign bus.db_mask_wr   = db_mask_wr_c;
  assign bus.db_pole_wr   = db_pole_wr_c;
  assign bus.db_vars_wr   = db_vars_wr_c;
endmodule

// File: doc/clause_db_ctrl.md
Name: clause_db_ctrl

Overview:
- Sequencing and arbitration controller in front of the clause database storage array.
- Owns clause_count and the storage address, write and read strobes.
- Serves three requesters: the CNF loader appends clauses, the solver issues single-clause random reads, and the BCP engine requests a full sweep that streams every stored clause in index order over a valid/ready interface.

Parameters:
- DB_SIZE, 512, number of clause rows; index width CW = $clog2(DB_SIZE).
- VAR_W, 9, width of one variable ID.
- LITS, 5, literal slots per clause; vars buses are LITS*VAR_W bits, var1 in the LSBs.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- clear  in  1  flush database (count to 0), honoured only in IDLE
- load_valid  in  1  loader offers a clause
- load_ready  out  1  controller accepts the clause this cycle
- load_mask  in  LITS  literal-present bits
- load_pole  in  LITS  literal polarity bits
- load_vars  in  LITS*VAR_W  variable IDs
- overflow  out  1  sticky; a load was attempted while full
- rd_req  in  1  solver random-read request
- rd_idx  in  CW  clause index to read
- rd_gnt  out  1  pulse; request accepted
- rd_valid  out  1  pulse; rd_* data valid
- rd_mask, rd_pole, rd_vars  out  LITS / LITS / LITS*VAR_W  random-read data
- sweep_start  in  1  begin full sweep
- sweep_abort  in  1  terminate sweep
- sweep_busy  out  1  sweep in progress
- sweep_done  out  1  pulse; last clause handed off
- out_valid  in←/out  out  1  sweep stream valid
- out_ready  in  1  BCP engine accepts
- out_idx  out  CW  index of streamed clause
- out_mask, out_pole, out_vars  out  LITS / LITS / LITS*VAR_W  streamed clause
- clause_count  out  CW+1  number of stored clauses
- full  out  1  clause_count == DB_SIZE
- db_we, db_re  out  1  storage strobes
- db_addr  out  CW  storage row
- db_mask_wr, db_pole_wr, db_vars_wr  out  as load_*  write data
- db_mask_rd, db_pole_rd, db_vars_rd  in  as load_*  read data, valid the cycle after db_re

Behaviour:
- Reset: state IDLE, clause_count=0, overflow=0; every output 0, including load_ready.
- States: IDLE, RAND_WAIT, SWEEP_ISSUE, SWEEP_WAIT, SWEEP_OUT.
- IDLE arbitration, highest priority first:
  - clear: count←0 next cycle; load_ready=0 this cycle.
  - load: load_ready = IDLE && !full && !clear, combinational. On load_valid&&load_ready, in the same cycle: db_we=1, db_addr=clause_count[CW-1:0], db_*_wr=load_*. count+1 next cycle.
  - rd_req: only if no load handshake this cycle; rd_gnt=1.
    - In range (rd_idx < count): db_re=1, db_addr=rd_idx, go to RAND_WAIT. Next cycle rd_valid=1, rd_*=db_*_rd, return to IDLE.
    - Out of range: no db_re; next cycle rd_valid=1 with rd_*=0.
  - sweep_start: only if no load or rd this cycle.
    - count==0: sweep_done pulses next cycle, no output.
    - Otherwise sweep_idx←0, go to SWEEP_ISSUE.
- Full handling: load_valid while full sets overflow (sticky until reset); load_ready stays 0; no write.
- SWEEP_ISSUE: db_re=1, db_addr=sweep_idx, go to SWEEP_WAIT.
- SWEEP_WAIT: capture db_*_rd and sweep_idx into the out_* registers; out_valid=1 from the next cycle; go to SWEEP_OUT.
- SWEEP_OUT: out_* held stable while out_valid && !out_ready. On handshake:
  - If sweep_idx==count-1: sweep_done pulses next cycle, out_valid←0, go to IDLE.
  - Else sweep_idx+1, go to SWEEP_ISSUE.
  - Throughput is one clause per 3 cycles with out_ready tied high.
- sweep_busy=1 in every SWEEP_* state.
- sweep_abort in any SWEEP_* state: IDLE next cycle, out_valid←0, no sweep_done. Abort wins over a same-cycle handshake.
- Outside IDLE: load_ready=0 and rd_gnt=0; requesters hold their requests. clear, and sweep_start while busy, are ignored.
- clause_count is CW+1 bits so 512 is representable; no wrap.

Test Plan:
- Reset, then 3 loads with load_valid held high → db_we on 3 consecutive cycles, addr 0,1,2; clause_count=3; load_ready=1 throughout.
- Load to DB_SIZE=4 (param override), 5th load_valid → load_ready=0, overflow=1 and stays 1, no db_we, count=4.
- count=3, rd_req with rd_idx=1 → rd_gnt pulse, db_re addr 1, rd_valid next cycle carrying row 1. rd_idx=3 → rd_valid with all-zero data, no db_re.
- count=3, sweep_start, out_ready toggling 1,0,1 → out_idx 0,1,2 in order; data stable during stall; sweep_done pulses once after idx 2; sweep_busy falls the same cycle.
- sweep_start with count=0 → sweep_done next cycle, out_valid never 1. sweep_abort during SWEEP_OUT idx 1 → IDLE, no sweep_done. Simultaneous load_valid+rd_req in IDLE → load wins, rd_gnt the next cycle.
- clear with count=5 → count=0 next cycle; subsequent load writes addr 0. Reset mid-sweep → all outputs 0 next cycle.
